// File: rtl/rv_pkg.sv
// rv_pkg: shared opcode/funct constants and ALU operation encoding for the core.
package rv_pkg;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [2:0] F3_ADD   = 3'b000;
  localparam logic [2:0] F3_AND   = 3'b111;
  localparam logic [2:0] F3_OR    = 3'b110;
  localparam logic [6:0] F7_BASE  = 7'b0000000;
  localparam logic [6:0] F7_SUB   = 7'b0100000;
  typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR} alu_op_t;
endpackage

// File: rtl/riscv_top_module_if.sv
// rf_if: register file access bus; the core drives addresses and the write, the file returns read data.
interface rf_if #(parameter int XLEN = 32);
  logic [4:0]      ra1;
  logic [4:0]      ra2;
  logic [XLEN-1:0] rd1;
  logic [XLEN-1:0] rd2;
  logic            we;
  logic [4:0]      wa;
  logic [XLEN-1:0] wd;
  modport master (output ra1, ra2, we, wa, wd, input rd1, rd2);
  modport slave (input ra1, ra2, we, wa, wd, output rd1, rd2);
endinterface

// File: rtl/riscv_top_module_instr_mem.sv
// instr_mem: byte-addressed little-endian instruction store with wrapping combinational word fetch.
module instr_mem #(
  parameter int IMEM_BYTES = 256,
  localparam int AW = $clog2(IMEM_BYTES)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] addr_i,
  output logic [31:0]   instr_o
);
  logic [7:0] array [0:IMEM_BYTES-1];
  // Byte-wide load port; the core ties it off and benches preload hierarchically.
  always_ff @(posedge clk)
    if (we_i) array[waddr_i] <= wdata_i;
  assign instr_o = {array[addr_i + AW'(3)], array[addr_i + AW'(2)],
                    array[addr_i + AW'(1)], array[addr_i]};
endmodule

// File: rtl/riscv_top_module_reg_file.sv
// reg_file: 32-entry register file, two combinational reads, one write, x0 hardwired to zero.
module reg_file #(
  parameter int XLEN = 32
) (
  input logic clk,
  rf_if.slave rf
);
  logic [XLEN-1:0] array [0:31];
  always_ff @(posedge clk)
    if (rf.we && rf.wa != 5'd0) array[rf.wa] <= rf.wd;
  assign rf.rd1 = rf.ra1 == 5'd0 ? '0 : array[rf.ra1];
  assign rf.rd2 = rf.ra2 == 5'd0 ? '0 : array[rf.ra2];
endmodule

// File: rtl/riscv_top_module.sv
// riscv_top_module: single-cycle RV32I subset core (ADD/SUB/AND/OR/ADDI), one instruction per clock.
module riscv_top_module
  import rv_pkg::*;
#(
  parameter int IMEM_BYTES = 256,
  parameter int XLEN = 32
) (
  input logic clk,
  input logic rst
);
  localparam int AW = $clog2(IMEM_BYTES);
  logic [31:0] pc_q = '0;
  logic [31:0] pc_d;
  logic [31:0] instr;
  logic [6:0]  opcode, f7;
  logic [2:0]  f3;
  logic        is_r, is_i;
  alu_op_t     alu_op;
  logic [XLEN-1:0] imm, op_b;
  rf_if #(.XLEN(XLEN)) rf ();
  instr_mem #(.IMEM_BYTES(IMEM_BYTES)) instruction_memory (
    .clk(clk), .we_i(1'b0), .waddr_i('0), .wdata_i('0),
    .addr_i(pc_q[AW-1:0]), .instr_o(instr)
  );
  reg_file #(.XLEN(XLEN)) regfile (.clk(clk), .rf(rf.slave));
  assign opcode = instr[6:0];
  assign f3 = instr[14:12];
  assign f7 = instr[31:25];
  assign is_r = opcode == OP_R &&
                ((f3 == F3_ADD && (f7 == F7_BASE || f7 == F7_SUB)) ||
                 ((f3 == F3_AND || f3 == F3_OR) && f7 == F7_BASE));
  assign is_i = opcode == OP_I && f3 == F3_ADD;
  assign alu_op = !is_r ? ALU_ADD : f3 == F3_AND ? ALU_AND : f3 == F3_OR ? ALU_OR :
                  f7 == F7_SUB ? ALU_SUB : ALU_ADD;
  assign imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
  assign op_b = is_i ? imm : rf.rd2;
  assign rf.ra1 = instr[19:15];
  assign rf.ra2 = instr[24:20];
  assign rf.wa = instr[11:7];
  // Writes are suppressed in a reset cycle so a restart never commits a stray result.
  assign rf.we = (is_r || is_i) && !rst;
  assign rf.wd = alu_op == ALU_SUB ? rf.rd1 - op_b : alu_op == ALU_AND ? rf.rd1 & op_b :
                 alu_op == ALU_OR ? rf.rd1 | op_b : rf.rd1 + op_b;
  assign pc_d = pc_q + 32'd4;
  always_ff @(posedge clk)
    pc_q <= rst ? '0 : pc_d;
endmodule

// File: tb/tb_riscv_top_module.sv
// tb_riscv_top_module: directed program run with hand-computed register/PC expectations.
module tb_riscv_top_module;
  logic clk = 0;
  logic rst = 0;
  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_x [0:31];
  logic [31:0] prog [0:9];
  rf_if #(.XLEN(32)) spare_if ();
  riscv_top_module #(.IMEM_BYTES(256), .XLEN(32)) dut (.clk(clk), .rst(rst));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_all(input string tag);
    for (int i = 0; i < 32; i++) chk($sformatf("%s x%0d", tag, i), dut.regfile.array[i], exp_x[i]);
  endtask
  initial begin
    prog = '{32'h00007033, 32'h00100093, 32'h00208433, 32'h404404b3, 32'h00317533,
             32'h0041e5b3, 32'h00007033, 32'h00007033, 32'hFFFFFFFF, 32'hFFF00293};
    for (int i = 0; i < 256; i++) dut.instruction_memory.array[i] = 8'hFF;
    for (int w = 0; w < 10; w++)
      for (int b = 0; b < 4; b++) dut.instruction_memory.array[w*4+b] = prog[w][b*8 +: 8];
    for (int i = 0; i < 32; i++) begin
      dut.regfile.array[i] = 32'(i);
      exp_x[i] = 32'(i);
    end
    exp_x[0] = 0;
    #1;
    chk("pc start", dut.pc_q, 32'd0);
    step();
    chk("and x0 keeps x0", dut.regfile.array[0], 32'd0);
    chk("pc after 1", dut.pc_q, 32'd4);
    step(); exp_x[1] = 32'd1;
    chk("addi x1", dut.regfile.array[1], exp_x[1]);
    step(); exp_x[8] = 32'd3;
    chk("add x8", dut.regfile.array[8], exp_x[8]);
    step(); exp_x[9] = 32'hFFFFFFFF;
    chk("sub x9 wrap", dut.regfile.array[9], exp_x[9]);
    step(); exp_x[10] = 32'd2;
    chk("and x10", dut.regfile.array[10], exp_x[10]);
    step(); exp_x[11] = 32'd7;
    chk("or x11", dut.regfile.array[11], exp_x[11]);
    chk("pc after 6", dut.pc_q, 32'd24);
    step(); step();
    chk("pc after 8", dut.pc_q, 32'd32);
    step();
    chk("pc after unknown", dut.pc_q, 32'd36);
    chk_all("unknown op");
    rst = 1;
    step();
    rst = 0;
    chk("pc after reset", dut.pc_q, 32'd0);
    chk("x5 write suppressed in reset", dut.regfile.array[5], 32'd5);
    chk_all("after reset");
    step();
    chk("pc resume", dut.pc_q, 32'd4);
    for (int i = 0; i < 9; i++) step();
    exp_x[5] = 32'hFFFFFFFF;
    chk("addi x5 -1", dut.regfile.array[5], exp_x[5]);
    chk("pc after rerun", dut.pc_q, 32'd40);
    chk_all("final");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
